// File: rtl/tu_pkg.sv
// Shared trigger-unit link definitions for the transmit framer and receive FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tu_pkg;

    // Link word width and the reserved idle word the receiver ignores.
    localparam int          TU_WORD_W        = 64;
    localparam logic [63:0] TU_IDLE_WORD     = 64'd0;
    localparam logic [63:0] TU_TRAIN_PATTERN = 64'hF0F0_F0F0_F0F0_F0F0;

    typedef logic [TU_WORD_W-1:0] tu_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } tu_state_t;

endpackage

// File: rtl/tu_sync_fifo.sv
// Circular-buffer FIFO with push/pop/flush, registered level and full flags.
// Latency: a pushed word reaches the head one cycle later; there is no bypass.
// Backpressure: caller must not push while full unless it pops in the same cycle.
module tu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [LW-1:0]    level,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
    end

    // Storage array; no reset needed since level gates what is readable.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
        end
    end

    assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/tu_tx_framer.sv
// Trigger-link transmit framer: training burst after each enable, then one buffered word per cycle.
// Latency: in RUN a word written at edge k is on tx_data after edge k+1; outputs all registered.
// Backpressure: none toward the link; writes with no room are dropped and flagged in sticky overflow.
module tu_tx_framer
    import tu_pkg::*;
#(
    parameter int          DEPTH         = 4,
    parameter int          TRAIN_WORDS   = 16,
    parameter logic [63:0] TRAIN_PATTERN = TU_TRAIN_PATTERN
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic                         tx_ena,
    input  logic                         wr_en,
    input  logic [63:0]                  wr_data,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         train_done,
    output logic [63:0]                  tx_data,
    output logic                         tx_valid
);

    localparam int LW = $clog2(DEPTH + 1);

    tu_state_t  state;
    tu_state_t  state_nxt;
    logic [7:0] train_cnt;
    tu_word_t   head_dat;
    tu_word_t   tx_data_nxt;
    logic       tx_valid_nxt;
    logic       wr_nz;
    logic       active;
    logic       pop;
    logic       push;
    logic       drop;

    assign wr_nz  = wr_en && (wr_data != TU_IDLE_WORD);
    assign active = tx_ena && (state != ST_IDLE);
    assign pop    = tx_ena && (state == ST_RUN) && (level != '0);
    assign push   = active && wr_nz && (!full || pop);
    assign drop   = active && wr_nz && full && !pop;

    tu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TU_WORD_W),
        .LW    (LW)
    ) u_fifo (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .flush    (!tx_ena),
        .push     (push),
        .push_dat (wr_data),
        .pop      (pop),
        .pop_dat  (head_dat),
        .level    (level),
        .full     (full)
    );

    // State register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: dropping tx_ena always returns to IDLE; TRAIN ends on its last pattern word.
    always_comb begin
        state_nxt = state;
        if (!tx_ena) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_TRAIN;
                ST_TRAIN: if (train_cnt == 8'd1) state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Link word for the next cycle: pattern while training, head word or idle while running.
    always_comb begin
        tx_data_nxt  = TU_IDLE_WORD;
        tx_valid_nxt = 1'b0;
        if (tx_ena) begin
            case (state)
                ST_TRAIN: tx_data_nxt = TRAIN_PATTERN;
                ST_RUN: begin
                    if (pop) begin
                        tx_data_nxt  = head_dat;
                        tx_valid_nxt = 1'b1;
                    end
                end
                default: tx_data_nxt = TU_IDLE_WORD;
            endcase
        end
    end

    // Counter is reloaded while idle so every enable gets the full burst.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            train_cnt <= 8'(TRAIN_WORDS);
        end else if (state == ST_IDLE) begin
            train_cnt <= 8'(TRAIN_WORDS);
        end else if (state == ST_TRAIN) begin
            train_cnt <= train_cnt - 8'd1;
        end
    end

    // Output register, train_done tracking the RUN state, and the sticky overflow flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tx_data    <= TU_IDLE_WORD;
            tx_valid   <= 1'b0;
            train_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            tx_data    <= tx_data_nxt;
            tx_valid   <= tx_valid_nxt;
            train_done <= (state_nxt == ST_RUN);
            if (!tx_ena) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tu_tx_framer.sv
// Bench for tu_tx_framer: queue-based reference model compared every cycle, plus directed literal checks.
// Latency: model produces the expected outputs after each rising edge; compared on the falling edge.
// Backpressure: stimulus deliberately overfills during training and drops tx_ena mid-stream.
module tb_tu_tx_framer;

    localparam int          DEPTH = 4;
    localparam int          TW    = 16;
    localparam logic [63:0] PAT   = 64'hF0F0_F0F0_F0F0_F0F0;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN;
    logic        tx_ena;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        full;
    logic [2:0]  level;
    logic        overflow;
    logic        train_done;
    logic [63:0] tx_data;
    logic        tx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    tu_tx_framer #(
        .DEPTH         (DEPTH),
        .TRAIN_WORDS   (TW),
        .TRAIN_PATTERN (PAT)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .tx_ena        (tx_ena),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .level         (level),
        .overflow      (overflow),
        .train_done    (train_done),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = link down, 1 = sending training words, 2 = streaming
    int          m_mode = 0;
    int          m_left = 0;
    bit          m_ovf  = 0;
    logic [63:0] m_q[$];
    logic [63:0] e_data  = 64'd0;
    bit          e_valid = 0;

    always @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN || !tx_ena) begin
            m_q.delete();
            m_mode  = 0;
            m_left  = 0;
            m_ovf   = 0;
            e_data  = 64'd0;
            e_valid = 0;
        end else begin
            e_data  = 64'd0;
            e_valid = 0;
            if (m_mode == 0) begin
                m_mode = 1;
                m_left = TW;
            end else begin
                if (m_mode == 1) begin
                    e_data = PAT;
                    m_left--;
                end else if (m_q.size() > 0) begin
                    e_data  = m_q.pop_front();
                    e_valid = 1;
                end
                if (wr_en && wr_data != 64'd0) begin
                    if (m_q.size() < DEPTH) m_q.push_back(wr_data);
                    else m_ovf = 1;
                end
                if (m_mode == 1 && m_left == 0) m_mode = 2;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge S_AXI_ACLK) begin
        chk("cmp_tx_data",    tx_data,           e_data);
        chk("cmp_tx_valid",   64'(tx_valid),     64'(e_valid));
        chk("cmp_level",      64'(level),        64'(m_q.size()));
        chk("cmp_full",       64'(full),         64'(m_q.size() == DEPTH));
        chk("cmp_overflow",   64'(overflow),     64'(m_ovf));
        chk("cmp_train_done", 64'(train_done),   64'(m_mode == 2));
    end

    // ---------------- directed helpers ----------------
    task automatic drive(input logic e, input logic we, input logic [63:0] d);
        tx_ena  = e;
        wr_en   = we;
        wr_data = d;
    endtask

    // Raise tx_ena, optionally write nwr words (base, base+1, ...) during training,
    // and count how many pattern words appear before train_done.
    task automatic enable_and_count(input int nwr, input logic [63:0] base, output int n);
        bit done = 0;
        n = 0;
        drive(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge S_AXI_ACLK);
            if (tx_data == PAT) n++;
            if (train_done) done = 1;
            if (!done && i < nwr) drive(1'b1, 1'b1, base + 64'(i));
            else drive(1'b1, 1'b0, 64'd0);
        end
        if (!done) chk("train_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        S_AXI_ARESETN = 1'b0;
        drive(1'b0, 1'b0, 64'd0);
        repeat (2) @(negedge S_AXI_ACLK);
        chk("rst_tx_data",    tx_data,          64'd0);
        chk("rst_tx_valid",   64'(tx_valid),    64'd0);
        chk("rst_full",       64'(full),        64'd0);
        chk("rst_level",      64'(level),       64'd0);
        chk("rst_overflow",   64'(overflow),    64'd0);
        chk("rst_train_done", 64'(train_done),  64'd0);
        S_AXI_ARESETN = 1'b1;
        @(negedge S_AXI_ACLK);

        // Training burst with no writes.
        enable_and_count(0, 64'd0, n);
        chk("train_count", 64'(n), 64'd16);
        @(negedge S_AXI_ACLK);
        chk("run_idle_data",  tx_data,         64'd0);
        chk("run_idle_valid", 64'(tx_valid),   64'd0);
        chk("run_train_done", 64'(train_done), 64'd1);

        // Back-to-back writes stream out one cycle later.
        drive(1'b1, 1'b1, 64'h1);
        @(negedge S_AXI_ACLK);
        chk("w1_level", 64'(level), 64'd1);
        chk("w1_valid", 64'(tx_valid), 64'd0);
        drive(1'b1, 1'b1, 64'h2);
        @(negedge S_AXI_ACLK);
        chk("w1_data", tx_data, 64'h1);
        chk("w2_level", 64'(level), 64'd1);
        drive(1'b1, 1'b1, 64'h3);
        @(negedge S_AXI_ACLK);
        chk("w2_data", tx_data, 64'h2);
        chk("w3_level", 64'(level), 64'd1);
        drive(1'b1, 1'b0, 64'd0);
        @(negedge S_AXI_ACLK);
        chk("w3_data", tx_data, 64'h3);
        chk("w3_valid", 64'(tx_valid), 64'd1);

        // Zero word is discarded and never flags overflow.
        drive(1'b1, 1'b1, 64'd0);
        @(negedge S_AXI_ACLK);
        chk("zero_level", 64'(level), 64'd0);
        chk("zero_ovf",   64'(overflow), 64'd0);
        drive(1'b1, 1'b0, 64'd0);
        @(negedge S_AXI_ACLK);
        chk("zero_valid", 64'(tx_valid), 64'd0);

        // Overfill during training: first four kept, overflow set.
        drive(1'b0, 1'b0, 64'd0);
        @(negedge S_AXI_ACLK);
        enable_and_count(6, 64'h11, n);
        chk("of_train_count", 64'(n), 64'd16);
        chk("of_level", 64'(level), 64'd4);
        chk("of_full",  64'(full), 64'd1);
        chk("of_ovf",   64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge S_AXI_ACLK);
            chk("of_order", tx_data, 64'h11 + 64'(i));
            chk("of_valid", 64'(tx_valid), 64'd1);
        end
        @(negedge S_AXI_ACLK);
        chk("of_drained", 64'(tx_valid), 64'd0);

        // Full FIFO in RUN with simultaneous writes, then drop tx_ena with 3 buffered.
        drive(1'b0, 1'b0, 64'd0);
        @(negedge S_AXI_ACLK);
        chk("flush_ovf", 64'(overflow), 64'd0);
        enable_and_count(4, 64'h21, n);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_ovf",   64'(overflow), 64'd0);
        drive(1'b1, 1'b1, 64'h25);
        @(negedge S_AXI_ACLK);
        chk("pp_data1",  tx_data, 64'h21);
        chk("pp_level1", 64'(level), 64'd4);
        chk("pp_ovf1",   64'(overflow), 64'd0);
        drive(1'b1, 1'b1, 64'h26);
        @(negedge S_AXI_ACLK);
        chk("pp_data2",  tx_data, 64'h22);
        chk("pp_level2", 64'(level), 64'd4);
        drive(1'b1, 1'b0, 64'd0);
        @(negedge S_AXI_ACLK);
        chk("pp_data3",  tx_data, 64'h23);
        chk("pp_level3", 64'(level), 64'd3);
        drive(1'b0, 1'b0, 64'd0);
        @(negedge S_AXI_ACLK);
        chk("drop_data",  tx_data, 64'd0);
        chk("drop_valid", 64'(tx_valid), 64'd0);
        chk("drop_level", 64'(level), 64'd0);
        chk("drop_ovf",   64'(overflow), 64'd0);
        enable_and_count(0, 64'd0, n);
        chk("retrain_count", 64'(n), 64'd16);
        @(negedge S_AXI_ACLK);
        chk("retrain_lost", 64'(tx_valid), 64'd0);

        // Randomized traffic with occasional link drops.
        for (int i = 0; i < 3000; i++) begin
            tx_ena  = ($urandom_range(0, 39) != 0);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            @(negedge S_AXI_ACLK);
            if (i == 1500) begin
                @(posedge S_AXI_ACLK);
                #2 S_AXI_ARESETN = 1'b0;
                #1;
                chk("arst_tx_data",    tx_data,          64'd0);
                chk("arst_tx_valid",   64'(tx_valid),    64'd0);
                chk("arst_level",      64'(level),       64'd0);
                chk("arst_overflow",   64'(overflow),    64'd0);
                chk("arst_train_done", 64'(train_done),  64'd0);
                @(negedge S_AXI_ACLK);
                S_AXI_ARESETN = 1'b1;
            end
        end

        drive(1'b0, 1'b0, 64'd0);
        @(negedge S_AXI_ACLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
